// File: rtl/cp0_intc_if.sv
// CP0 interrupt-controller bus: pipeline-side register access, victim info and the flush request.
// The master modport is the pipeline, the slave modport is the coprocessor.
interface cp0_intc_if #(
  parameter int NUM_HWINT = 6
);
  logic [NUM_HWINT-1:0] HWInt;
  logic [4:0]           A1;
  logic [4:0]           A2;
  logic [31:0]          WData;
  logic                 We;
  logic [31:0]          VPC;
  logic                 BDIn;
  logic [4:0]           ExcCodeIn;
  logic                 EXLClr;
  logic                 Req;
  logic [31:0]          EPCOut;
  logic [31:0]          RData;

  modport master (
    output HWInt, A1, A2, WData, We, VPC, BDIn, ExcCodeIn, EXLClr,
    input  Req, EPCOut, RData
  );

  modport slave (
    input  HWInt, A1, A2, WData, We, VPC, BDIn, ExcCodeIn, EXLClr,
    output Req, EPCOut, RData
  );
endinterface

// File: rtl/cp0_intc.sv
// CP0 SR/Cause/EPC/PRId with interrupt sampling; Req and RData are combinational, state updates next edge.
// No backpressure: a raised Req takes the exception on the next edge and masks mtc0 in that cycle.
module cp0_intc #(
  parameter int                   NUM_HWINT  = 6,
  parameter logic [NUM_HWINT-1:0] EDGE_MASK  = '0,
  parameter logic [31:0]          PRID_VALUE = 32'h0000_0007
) (
  input logic         Clk,
  input logic         Reset,
  cp0_intc_if.slave   bus
);
  localparam int IP_LO = 10;

  logic [NUM_HWINT-1:0] hwSample;
  logic [NUM_HWINT-1:0] edgePend;
  logic [NUM_HWINT-1:0] im;
  logic                 ie;
  logic                 exl;
  logic                 bd;
  logic [4:0]           excCode;
  logic [31:0]          epc;

  logic [NUM_HWINT-1:0] ip;
  logic [NUM_HWINT-1:0] edgeRise;
  logic [NUM_HWINT-1:0] causeClr;
  logic                 intReq;
  logic                 excReq;
  logic                 req;
  logic                 wrEn;
  logic                 wrSr;
  logic                 wrCause;
  logic                 wrEpc;
  logic [31:0]          victimPc;

  // Level lines follow the sample; edge lines show their sticky pending bit.
  assign ip       = (hwSample & ~EDGE_MASK) | (edgePend & EDGE_MASK);
  assign edgeRise = bus.HWInt & ~hwSample;

  assign intReq = (|(ip & im)) & ie & ~exl;
  assign excReq = (bus.ExcCodeIn != 5'd0) & ~exl;
  assign req    = intReq | excReq;

  assign wrEn    = bus.We & ~req;
  assign wrSr    = wrEn && (bus.A2 == 5'd12);
  assign wrCause = wrEn && (bus.A2 == 5'd13);
  assign wrEpc   = wrEn && (bus.A2 == 5'd14);

  assign causeClr = wrCause ? ~bus.WData[IP_LO +: NUM_HWINT] : '0;
  assign victimPc = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hwSample <= '0;
      edgePend <= '0;
      im       <= '0;
      ie       <= 1'b0;
      exl      <= 1'b0;
      bd       <= 1'b0;
      excCode  <= 5'd0;
      epc      <= 32'd0;
    end else begin
      hwSample <= bus.HWInt;
      // A rise in the clearing cycle re-arms the bit.
      edgePend <= ((edgePend & ~causeClr) | edgeRise) & EDGE_MASK;

      if (wrSr) begin
        im <= bus.WData[IP_LO +: NUM_HWINT];
        ie <= bus.WData[0];
      end

      // Exception entry sets EXL; eret beats a concurrent software write of EXL.
      if (req)             exl <= 1'b1;
      else if (bus.EXLClr) exl <= 1'b0;
      else if (wrSr)       exl <= bus.WData[1];

      if (req) begin
        bd      <= bus.BDIn;
        excCode <= intReq ? 5'd0 : bus.ExcCodeIn;
        epc     <= {victimPc[31:2], 2'b00};
      end else if (wrEpc) begin
        epc <= {bus.WData[31:2], 2'b00};
      end
    end
  end

  logic [31:0] srVal;
  logic [31:0] causeVal;

  always_comb begin
    srVal                       = '0;
    srVal[IP_LO +: NUM_HWINT]   = im;
    srVal[1]                    = exl;
    srVal[0]                    = ie;
    causeVal                    = '0;
    causeVal[31]                = bd;
    causeVal[IP_LO +: NUM_HWINT] = ip;
    causeVal[6:2]               = excCode;
    case (bus.A1)
      5'd12:   bus.RData = srVal;
      5'd13:   bus.RData = causeVal;
      5'd14:   bus.RData = epc;
      5'd15:   bus.RData = PRID_VALUE;
      default: bus.RData = '0;
    endcase
  end

  assign bus.Req    = req;
  assign bus.EPCOut = epc;
endmodule

// File: doc/cp0_intc.md
CP0_INTC -- requirements
Module: cp0_intc

Interface
REQ-001 SHALL have parameter NUM_HWINT, default 6, meaning number of hardware interrupt lines (legal 1..6, mapped to IP/IM bits 10..10+NUM_HWINT-1).
REQ-002 SHALL have parameter EDGE_MASK, default 0, meaning a NUM_HWINT-bit mask; a set bit makes that line edge-triggered, a clear bit makes it level-triggered.
REQ-003 SHALL have parameter PRID_VALUE, default 32'h0000_0007, meaning the constant returned by PRId.
REQ-004 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  reset, synchronous and active-high.
REQ-006 HWInt  input  NUM_HWINT  raw interrupt lines.
REQ-007 A1  input  5  CP0 read register number (mfc0).
REQ-008 A2  input  5  CP0 write register number (mtc0).
REQ-009 WData  input  32  mtc0 write data.
REQ-010 We  input  1  mtc0 write enable.
REQ-011 VPC  input  32  PC of the victim instruction.
REQ-012 BDIn  input  1  victim instruction sits in a branch delay slot.
REQ-013 ExcCodeIn  input  5  synchronous exception code; 0 means none.
REQ-014 EXLClr  input  1  eret commit; clears SR.EXL.
REQ-015 Req  output  1  interrupt/exception request to the pipeline flush logic.
REQ-016 EPCOut  output  32  current EPC register value.
REQ-017 RData  output  32  read data for register A1.

Function
REQ-018 Registers SHALL be SR(12): IM[15:10], EXL[1], IE[0]; Cause(13): BD[31], IP[15:10], ExcCode[6:2]; EPC(14); PRId(15); all other bits read 0.
REQ-019 IM/IP bits at or above 10+NUM_HWINT SHALL be hardwired 0 and ignore writes.
REQ-020 Level lines SHALL drive IP directly from a one-cycle registered copy of HWInt.
REQ-021 Edge lines SHALL set a pending bit when the registered sample goes 0->1; the pending bit holds until mtc0 to Cause writes 0 to that IP bit; a new edge in the clearing cycle wins (bit stays 1).
REQ-022 IntReq SHALL be combinational: |(IP & IM) & IE & ~EXL.
REQ-023 ExcReq SHALL be combinational: (ExcCodeIn != 0) & ~EXL.
REQ-024 Req SHALL equal IntReq | ExcReq, with no added latency.
REQ-025 On a Req edge: EXL<=1; BD<=BDIn; EPC<=BDIn ? VPC-4 : VPC, low 2 bits forced 0; ExcCode<=0 when IntReq, else ExcCodeIn (interrupt beats exception).
REQ-026 When Req is high, mtc0 SHALL be suppressed in that cycle.
REQ-027 mtc0 SHALL write SR (IM, EXL, IE), EPC (bits [1:0] forced 0), and Cause edge-IP clear bits only; ExcCode, BD, level IP and PRId SHALL be read-only.
REQ-028 EXLClr SHALL clear EXL at the edge and take priority over a same-cycle mtc0 to SR.EXL.
REQ-029 RData SHALL be combinational from A1; unmapped numbers return 0; there is no write-to-read bypass (a same-cycle mtc0 is visible next cycle).
REQ-030 EPCOut SHALL be the EPC register, updated one edge after capture.
REQ-031 While EXL=1, no further Req SHALL assert; pending IP bits SHALL persist and fire after EXL clears and IE/IM permit.

Reset
REQ-032 On Reset: SR=0, Cause=0, EPC=0, all edge-pending and sampled HWInt bits 0; Req=0, EPCOut=0, RData=0 for A1 in {12,13,14}.
REQ-033 Reset SHALL override Req capture, mtc0 and EXLClr in the same cycle.

Verification
REQ-034 mtc0 SR=32'h0000_0401, HWInt[0] held 1 (level) -> Req=1 on the second edge after assertion; with VPC=32'h0000_3008, BDIn=0: EPC=32'h3008, ExcCode=0, EXL=1, Req drops.
REQ-035 EXL=0, ExcCodeIn=10, BDIn=1, VPC=32'h3010 -> Req=1 same cycle; next: EPC=32'h300C, BD=1, ExcCode=10.
REQ-036 Simultaneous enabled interrupt and ExcCodeIn=4 -> ExcCode=0, EPC=VPC.
REQ-037 EDGE_MASK=6'b000010, 1-cycle pulse on HWInt[1] with IM[11]=0 -> IP[11] stays 1; enabling IM[11]=1, IE=1 -> Req; mtc0 Cause=0 -> IP[11]=0.
REQ-038 EXLClr and mtc0 SR=32'h3 in the same cycle -> SR reads 32'h1.
REQ-039 Reset asserted in the same cycle as Req -> all registers 0, EPC not captured.
